// File: rtl/glitch_pkg.sv
// Shared types and default timing constants for the power-glitch campaign blocks.
package glitch_pkg;

    typedef enum logic [3:0] {
        IDLE, PWR_OFF, BOOT, ARM, DELAY, GLITCH, OBSERVE, NEXT, DONE
    } state_t;

    typedef enum logic [1:0] {
        NORMAL, FAULT, CRASH
    } outcome_t;

    typedef enum logic [1:0] {
        PH_IDLE, PH_WAIT, PH_CUT
    } pulse_phase_t;

    localparam int unsigned DEF_CLK_HZ       = 25_125_000;
    localparam int unsigned TRIG_TIMEOUT_DIV = 10;
    localparam int unsigned RESP_TIMEOUT_DIV = 100;

endpackage

// File: rtl/glitch_pulse_timer.sv
// Offset/width pulse timer: armed by a load strobe, it opens a power-cut window
// offset+1 cycles later, holds it for width cycles and flags the last cut cycle.
module glitch_pulse_timer
    import glitch_pkg::*;
#(
    parameter int OFF_W = 16,
    parameter int WID_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             load,
    input  logic [OFF_W-1:0] offset,
    input  logic [WID_W-1:0] width,
    output logic             window,
    output logic             win_next,
    output logic             pulse_done
);

    pulse_phase_t     phase;
    logic [OFF_W-1:0] off_cnt;
    logic [WID_W-1:0] wid_cnt;

    assign window     = (phase == PH_CUT);
    assign pulse_done = window && (wid_cnt <= WID_W'(1));
    assign win_next   = !clear && (load ? (offset == '0)
                                        : (phase == PH_WAIT && off_cnt == OFF_W'(1)));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase   <= PH_IDLE;
            off_cnt <= '0;
            wid_cnt <= '0;
        end else if (clear) begin
            phase <= PH_IDLE;
        end else if (load) begin
            off_cnt <= offset;
            wid_cnt <= width;
            phase   <= (offset == '0) ? PH_CUT : PH_WAIT;
        end else begin
            case (phase)
                PH_WAIT: begin
                    off_cnt <= off_cnt - 1'b1;
                    if (off_cnt == OFF_W'(1)) phase <= PH_CUT;
                end
                PH_CUT: begin
                    wid_cnt <= wid_cnt - 1'b1;
                    if (pulse_done) phase <= PH_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/glitch_sweep_sched.sv
// Power-glitch campaign scheduler: power-cycles the target, glitches after each
// trigger and sweeps (offset, width). Define STOP_ON_HIT_EN to end on the first fault.
module glitch_sweep_sched
    import glitch_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int          OFF_W        = 16,
    parameter int          WID_W        = 8,
    parameter int unsigned OFF_MIN      = 0,
    parameter int unsigned OFF_MAX      = 255,
    parameter int unsigned OFF_STEP     = 1,
    parameter int unsigned WID_MIN      = 1,
    parameter int unsigned WID_MAX      = 4,
    parameter int unsigned RESET_LEN    = CLK_HZ,
    parameter int unsigned BOOT_LEN     = CLK_HZ,
    parameter int unsigned TRIG_TIMEOUT = CLK_HZ / TRIG_TIMEOUT_DIV,
    parameter int unsigned RESP_TIMEOUT = CLK_HZ / RESP_TIMEOUT_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             trig_in,
    input  logic             resp_valid,
    input  logic             resp_fault,
    output logic             target_pwr,
    output logic             busy,
    output logic             done,
    output logic [OFF_W-1:0] cur_offset,
    output logic [WID_W-1:0] cur_width,
    output logic             hit,
    output logic [OFF_W-1:0] hit_offset,
    output logic [WID_W-1:0] hit_width,
    output logic [15:0]      hit_count
);

    state_t      state, state_nxt;
    outcome_t    outcome, outcome_nxt;
    logic [31:0] cnt;
    logic        trig_s1, trig_s2, trig_s3, trig_edge;
    logic        tmr_load, window, win_next, pulse_done;
    logic        launch, off_wrap, sweep_end;
    logic [OFF_W:0] off_sum;
    logic [WID_W:0] wid_sum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) {trig_s1, trig_s2, trig_s3} <= '0;
        else     {trig_s1, trig_s2, trig_s3} <= {trig_in, trig_s1, trig_s2};
    end
    assign trig_edge = trig_s2 && !trig_s3;

    glitch_pulse_timer #(.OFF_W(OFF_W), .WID_W(WID_W)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (abort),
        .load       (tmr_load),
        .offset     (cur_offset),
        .width      (cur_width),
        .window     (window),
        .win_next   (win_next),
        .pulse_done (pulse_done)
    );

    // One extra bit so an offset past OFF_MAX is seen instead of wrapping.
    assign off_sum   = {1'b0, cur_offset} + (OFF_W+1)'(OFF_STEP);
    assign off_wrap  = off_sum > (OFF_W+1)'(OFF_MAX);
    assign wid_sum   = {1'b0, cur_width} + 1'b1;
    assign sweep_end = off_wrap && (wid_sum > (WID_W+1)'(WID_MAX));

    assign launch = start && !abort && (state == IDLE || state == DONE);
    assign busy   = (state != IDLE) && (state != DONE);
    assign done   = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        outcome_nxt = outcome;
        tmr_load    = 1'b0;
        hit         = 1'b0;
        target_pwr  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = PWR_OFF;
            PWR_OFF: if (cnt == RESET_LEN - 1) state_nxt = BOOT;
            BOOT: begin
                target_pwr = 1'b1;
                if (cnt == BOOT_LEN - 1) state_nxt = ARM;
            end
            ARM: begin
                target_pwr = 1'b1;
                if (trig_edge) begin
                    tmr_load  = 1'b1;
                    state_nxt = win_next ? GLITCH : DELAY;
                end else if (cnt == TRIG_TIMEOUT - 1) begin
                    outcome_nxt = CRASH;
                    state_nxt   = NEXT;
                end
            end
            DELAY: begin
                target_pwr = !window;
                if (win_next) state_nxt = GLITCH;
            end
            GLITCH: begin
                target_pwr = !window;
                if (pulse_done) state_nxt = OBSERVE;
            end
            OBSERVE: begin
                target_pwr = 1'b1;
                if (resp_valid) begin
                    if (resp_fault) begin
                        hit         = 1'b1;
                        outcome_nxt = FAULT;
`ifdef STOP_ON_HIT_EN
                        state_nxt   = DONE;
`else
                        state_nxt   = NEXT;
`endif
                    end else begin
                        outcome_nxt = NORMAL;
                        state_nxt   = NEXT;
                    end
                end else if (cnt == RESP_TIMEOUT - 1) begin
                    outcome_nxt = CRASH;
                    state_nxt   = NEXT;
                end
            end
            NEXT: begin
                target_pwr = 1'b1;
                if (sweep_end)               state_nxt = DONE;
                else if (outcome == CRASH)   state_nxt = PWR_OFF;
                else                         state_nxt = ARM;
            end
            DONE: begin
                target_pwr = 1'b1;
                if (start) state_nxt = PWR_OFF;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            tmr_load  = 1'b0;
            hit       = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            outcome <= NORMAL;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            outcome <= outcome_nxt;
            if (state_nxt != state || !busy) cnt <= '0;
            else                             cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_offset <= OFF_W'(OFF_MIN);
            cur_width  <= WID_W'(WID_MIN);
            hit_offset <= '0;
            hit_width  <= '0;
            hit_count  <= '0;
        end else begin
            if (launch) begin
                cur_offset <= OFF_W'(OFF_MIN);
                cur_width  <= WID_W'(WID_MIN);
                hit_count  <= '0;
            end else if (state == NEXT && !abort && !sweep_end) begin
                if (off_wrap) begin
                    cur_offset <= OFF_W'(OFF_MIN);
                    cur_width  <= wid_sum[WID_W-1:0];
                end else begin
                    cur_offset <= off_sum[OFF_W-1:0];
                end
            end
            if (hit) begin
                hit_offset <= cur_offset;
                hit_width  <= cur_width;
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep_sched.sv
// Directed bench for glitch_sweep_sched: small 4x2 grid instance plus a wide
// offset instance exercising the no-wrap advance near 16-bit full scale.
module tb_glitch_sweep_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, abort = 1'b0, trig_in = 1'b0;
    logic        resp_valid = 1'b0, resp_fault = 1'b0;
    logic        target_pwr, busy, done, hit;
    logic [15:0] cur_offset, hit_offset, hit_count;
    logic [7:0]  cur_width, hit_width;

    logic        start2 = 1'b0, zero = 1'b0;
    logic        target_pwr2, busy2, done2, hit2;
    logic [15:0] cur_offset2, hit_offset2, hit_count2;
    logic [7:0]  cur_width2, hit_width2;

    int   checks = 0;
    int   errors = 0;
    int   low_cnt = 0;
    logic low_en = 1'b0;

    always #5 CLK = ~CLK;

    glitch_sweep_sched #(
        .OFF_MIN(0), .OFF_MAX(3), .OFF_STEP(1), .WID_MIN(1), .WID_MAX(2),
        .RESET_LEN(8), .BOOT_LEN(8), .TRIG_TIMEOUT(50), .RESP_TIMEOUT(30)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .trig_in(trig_in),
        .resp_valid(resp_valid), .resp_fault(resp_fault), .target_pwr(target_pwr),
        .busy(busy), .done(done), .cur_offset(cur_offset), .cur_width(cur_width),
        .hit(hit), .hit_offset(hit_offset), .hit_width(hit_width), .hit_count(hit_count)
    );

    glitch_sweep_sched #(
        .OFF_MIN(65530), .OFF_MAX(65535), .OFF_STEP(2), .WID_MIN(1), .WID_MAX(2),
        .RESET_LEN(8), .BOOT_LEN(8), .TRIG_TIMEOUT(10), .RESP_TIMEOUT(10)
    ) dut2 (
        .CLK(CLK), .RST(RST), .start(start2), .abort(zero), .trig_in(zero),
        .resp_valid(zero), .resp_fault(zero), .target_pwr(target_pwr2),
        .busy(busy2), .done(done2), .cur_offset(cur_offset2), .cur_width(cur_width2),
        .hit(hit2), .hit_offset(hit_offset2), .hit_width(hit_width2), .hit_count(hit_count2)
    );

    always @(negedge CLK) if (low_en && busy && !target_pwr) low_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Trigger rises in cycle k, so the internal strobe E is k+2 and the cut
    // spans k+3+off .. k+2+off+wid. Response (if any) goes in at k+11.
    task automatic do_point(input int off, input int wid, input bit resp, input bit fault);
        logic [10:0] pat, want;
        trig_in = 1'b1;
        smp();
        check($sformatf("cur_offset_%0d_%0d", off, wid), cur_offset, off);
        check($sformatf("cur_width_%0d_%0d", off, wid), cur_width, wid);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                cyc();
                smp();
            end
            pat[i]  = target_pwr;
            want[i] = !(i >= 3 + off && i <= 2 + off + wid);
        end
        check($sformatf("pwr_pattern_%0d_%0d", off, wid), pat, want);
        cyc();
        trig_in = 1'b0;
        if (resp) begin
            resp_valid = 1'b1;
            resp_fault = fault;
            smp();
            check($sformatf("hit_pulse_%0d_%0d", off, wid), hit, fault);
        end
        cyc();
        resp_valid = 1'b0;
        resp_fault = 1'b0;
    endtask

    task automatic wait_pwr(input logic val, input int max_cyc, input string tag);
        int n = 0;
        smp();
        while (target_pwr !== val && n < max_cyc) begin
            cyc();
            smp();
            n++;
        end
        check(tag, target_pwr, val);
    endtask

    task automatic launch();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] seen[$];
        logic [23:0] last, now;
        logic [23:0] want6 [6];

        // Reset state
        repeat (3) cyc();
        smp();
        check("rst_target_pwr", target_pwr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_cur_offset", cur_offset, 0);
        check("rst_cur_width", cur_width, 1);
        check("rst_hit_offset", hit_offset, 0);
        check("rst_hit_width", hit_width, 0);
        cyc();
        RST = 1'b0;

        // Basic sweep with exact cut timing per point
        launch();
        low_cnt = 0;
        low_en  = 1'b1;
        smp();
        check("start_busy", busy, 1);
        check("start_pwr_off", target_pwr, 0);
        repeat (20) cyc();
        for (int w = 1; w <= 2; w++) begin
            for (int o = 0; o <= 3; o++) begin
                do_point(o, w, 1'b1, 1'b0);
                if (!(w == 2 && o == 3)) repeat (3) cyc();
            end
        end
        cyc();
        smp();
        low_en = 1'b0;
        check("sweep_done", done, 1);
        check("sweep_busy", busy, 0);
        check("sweep_pwr_on", target_pwr, 1);
        check("sweep_last_offset", cur_offset, 3);
        check("sweep_last_width", cur_width, 2);
        check("sweep_low_cycles", low_cnt, 20);

        // Relaunch from DONE with a fault at (2,1)
        launch();
        repeat (20) cyc();
        do_point(0, 1, 1'b1, 1'b0);
        repeat (3) cyc();
        do_point(1, 1, 1'b1, 1'b0);
        repeat (3) cyc();
        do_point(2, 1, 1'b1, 1'b1);
        smp();
        check("hit_one_cycle", hit, 0);
        check("hit_offset", hit_offset, 2);
        check("hit_width", hit_width, 1);
        check("hit_count", hit_count, 1);
`ifdef STOP_ON_HIT_EN
        check("stop_on_hit_done", done, 1);
        check("stop_on_hit_offset", cur_offset, 2);
`else
        cyc();
        smp();
        check("after_hit_offset", cur_offset, 3);
        check("after_hit_not_done", done, 0);
`endif
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        smp();
        check("abort_busy", busy, 0);
        check("abort_pwr", target_pwr, 0);

        // Response timeout at (1,1), then trigger timeout at (2,1)
        launch();
        repeat (20) cyc();
        do_point(0, 1, 1'b1, 1'b0);
        repeat (3) cyc();
        do_point(1, 1, 1'b0, 1'b0);
        wait_pwr(1'b0, 60, "resp_timeout_pwr_off");
        check("resp_timeout_next_offset", cur_offset, 2);
        check("resp_timeout_next_width", cur_width, 1);
        wait_pwr(1'b1, 20, "resp_timeout_reboot");
        repeat (12) cyc();
        wait_pwr(1'b0, 80, "trig_timeout_pwr_off");
        check("trig_timeout_next_offset", cur_offset, 3);
        check("trig_timeout_next_width", cur_width, 1);

        // Abort while the glitch window is open at (3,1)
        wait_pwr(1'b1, 20, "boot_before_abort");
        repeat (12) cyc();
        trig_in = 1'b1;
        repeat (6) cyc();
        abort = 1'b1;
        smp();
        check("glitch_cut_before_abort", target_pwr, 0);
        cyc();
        abort   = 1'b0;
        trig_in = 1'b0;
        smp();
        check("abort_glitch_pwr", target_pwr, 0);
        check("abort_glitch_busy", busy, 0);
        check("abort_keeps_hit_offset", hit_offset, 2);
        check("abort_keeps_hit_width", hit_width, 1);

        // Asynchronous reset in BOOT
        launch();
        repeat (11) cyc();
        smp();
        check("boot_pwr_on", target_pwr, 1);
        check("boot_busy", busy, 1);
        #1 RST = 1'b1;
        #1;
        check("arst_target_pwr", target_pwr, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hit_offset", hit_offset, 0);
        check("arst_hit_width", hit_width, 0);
        check("arst_cur_offset", cur_offset, 0);
        check("arst_cur_width", cur_width, 1);
        cyc();
        cyc();
        RST = 1'b0;

        // Wide offset range: step 2 up to 65535 must advance width, not wrap
        want6[0] = {16'd65530, 8'd1};
        want6[1] = {16'd65532, 8'd1};
        want6[2] = {16'd65534, 8'd1};
        want6[3] = {16'd65530, 8'd2};
        want6[4] = {16'd65532, 8'd2};
        want6[5] = {16'd65534, 8'd2};
        cyc();
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        last = {cur_offset2, cur_width2};
        seen.push_back(last);
        for (int n = 0; n < 400; n++) begin
            smp();
            now = {cur_offset2, cur_width2};
            if (now !== last) seen.push_back(now);
            last = now;
            if (done2) break;
            cyc();
        end
        check("range_done", done2, 1);
        check("range_points", seen.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("range_point_%0d", i), (i < seen.size()) ? seen[i] : 24'h0, want6[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
